prm_edge_mask_collect: RTL

//  Drives the combinational prm_oblgc_chk* edge checkers with one 15-bit config/obstacle code per edge.

---
 rtl/prm_edge_pkg.sv | 19 +
 rtl/prm_mask_pack.sv | 86 ++++++++
 rtl/prm_edge_mask_collect.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/prm_edge_pkg.sv
// Shared constants, FSM state encoding and edge-code type for the edge-mask collector.
package prm_edge_pkg;

  localparam int CODE_W = 15;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 16;
  localparam int IDX_W  = $clog2(WORD_W);
  localparam int BITS_W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef logic [CODE_W-1:0] edge_code_t;

endpackage

// File: rtl/prm_mask_pack.sv
// Packs one checker result bit per edge into WORD_W-bit words behind a
// valid/ready output register that refills in the same cycle it drains.
module prm_mask_pack
  import prm_edge_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic              in_bit_i,
  input  logic              in_last_i,
  output logic              stall_o,
  output logic              fire_o,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [WORD_W-1:0] out_word_o,
  output logic              out_last_o,
  output logic [BITS_W-1:0] out_bits_o
);

  logic [WORD_W-1:0] acc_q, acc_d, acc_bit_s;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [BITS_W-1:0] bits_q, bits_d;
  logic              completes_s;

  assign completes_s = (idx_q == IDX_W'(WORD_W-1)) | in_last_i;
  // A completing edge must wait while the previous word is still unaccepted.
  assign stall_o     = in_valid_i & completes_s & valid_q & ~out_ready_i;
  assign fire_o      = in_valid_i & ~stall_o;
  assign acc_bit_s   = acc_q | (WORD_W'(in_bit_i) << idx_q);

  always_comb begin
    acc_d   = acc_q;
    idx_d   = idx_q;
    word_d  = word_q;
    valid_d = valid_q;
    last_d  = last_q;
    bits_d  = bits_q;
    if (valid_q & out_ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (fire_o) begin
      if (completes_s) begin
        word_d  = acc_bit_s;
        valid_d = 1'b1;
        last_d  = in_last_i;
        bits_d  = BITS_W'(idx_q) + BITS_W'(1);
        acc_d   = '0;
        idx_d   = '0;
      end else begin
        acc_d = acc_bit_s;
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      bits_q  <= '0;
    end else begin
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      bits_q  <= bits_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_word_o  = word_q;
  assign out_last_o  = last_q;
  assign out_bits_o  = bits_q;

endmodule

// File: rtl/prm_edge_mask_collect.sv
// Feeds edge codes to an external edge checker and streams packed edge_mask words.
// Optional PRM_MASK_POPCNT_EN adds free_cnt, the count of set mask bits per job.
module prm_edge_mask_collect
  import prm_edge_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_edges,
  output logic              busy,
  output logic              done,
  input  logic              code_valid,
  output logic              code_ready,
  input  edge_code_t        code_data,
  output edge_code_t        chk_code,
  input  logic              chk_mask,
  output logic              mask_valid,
  input  logic              mask_ready,
  output logic [WORD_W-1:0] mask_word,
  output logic              mask_last,
  output logic [BITS_W-1:0] mask_bits
`ifdef PRM_MASK_POPCNT_EN
  ,
  output logic [CNT_W-1:0]  free_cnt
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  edge_code_t       code_q, code_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s1_last_q, s1_last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             stall_s, fire_s, start_acc_s, code_acc_s, final_hs_s;

  // The done cycle still counts as busy, so a start there is ignored too.
  assign start_acc_s = start & (state_q == IDLE) & ~done_q;
  assign code_ready  = (state_q == RUN) & (rem_q != '0) & ~stall_s;
  assign code_acc_s  = code_valid & code_ready;
  assign final_hs_s  = mask_valid & mask_ready & mask_last;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    code_d     = code_q;
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    case (state_q)
      IDLE: begin
        if (start_acc_s) begin
          rem_d   = num_edges;
          state_d = (num_edges != '0) ? RUN : DONE;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (code_acc_s && (rem_q == CNT_W'(1))) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (final_hs_s) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (code_acc_s) begin
      rem_d      = rem_q - CNT_W'(1);
      code_d     = code_data;
      s1_valid_d = 1'b1;
      s1_last_d  = (rem_q == CNT_W'(1));
    end else if (!stall_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    done_d = (state_q == DONE);
    busy_d = (state_d != IDLE) | done_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      code_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      code_q     <= code_d;
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign chk_code = code_q;
  assign busy     = busy_q;
  assign done     = done_q;

  prm_mask_pack u_pack (
    .clk_i       (CLK),
    .rst_i       (RST),
    .in_valid_i  (s1_valid_q),
    .in_bit_i    (chk_mask),
    .in_last_i   (s1_last_q),
    .stall_o     (stall_s),
    .fire_o      (fire_s),
    .out_ready_i (mask_ready),
    .out_valid_o (mask_valid),
    .out_word_o  (mask_word),
    .out_last_o  (mask_last),
    .out_bits_o  (mask_bits)
  );

`ifdef PRM_MASK_POPCNT_EN
  logic [CNT_W-1:0] free_q, free_d;

  always_comb begin
    if (start_acc_s) begin
      free_d = '0;
    end else if (fire_s && chk_mask) begin
      free_d = free_q + CNT_W'(1);
    end else begin
      free_d = free_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      free_q <= '0;
    end else begin
      free_q <= free_d;
    end
  end

  assign free_cnt = free_q;
`else
  logic unused_fire_s;
  assign unused_fire_s = fire_s;
`endif

endmodule
